pipe_stage_reg: RTL and testbench

Generic elastic pipeline-stage register replacing the fixed per-stage latch banks between CPU stages (IF/ID, ID/EX, EX/WB). It carries a parametrised data bundle plus a control bundle under a valid/ready handshake, supports stall (back-pressure) and flush (bubble insertion), and gates control bits to zero whenever the stage holds a bubble. An optional skid buffer registers the upstream ready, cutting the combinational ready path through the pipeline.

---
 rtl/pipe_stage_reg.sv | 123 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register: data + control bundles under valid/ready with stall, flush and bubble gating.
// Define PIPE_REG_SKID_EN to add a skid entry and a registered in_ready (no out_ready -> in_ready comb path).
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [15:0]       stall_cnt
);

`ifdef PIPE_REG_SKID_EN
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
`else
  typedef enum logic {EMPTY = 1'b0, ONE = 1'b1} state_t;
`endif

  state_t            state, state_nxt;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic              acc, fire;

  assign out_valid = (state != EMPTY);
  assign out_data  = main_data;
  assign out_ctrl  = out_valid ? main_ctrl : '0;
  assign acc       = in_valid && in_ready;
  assign fire      = out_valid && out_ready;

`ifdef PIPE_REG_SKID_EN
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic              in_ready_q;

  // The flop resets high so the stage accepts in the first cycle after reset; rst masks it meanwhile.
  assign in_ready = !rst && in_ready_q;
`else
  assign in_ready = !rst && (!out_valid || out_ready);
`endif

  always_comb begin
    // NOTE: default assignment first so every path drives state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      EMPTY: if (acc) state_nxt = ONE;
`ifdef PIPE_REG_SKID_EN
      ONE: begin
        if (acc && !fire)      state_nxt = TWO;
        else if (!acc && fire) state_nxt = EMPTY;
      end
      TWO:     if (fire) state_nxt = ONE;
      default: state_nxt = EMPTY;
`else
      ONE: if (!acc && fire) state_nxt = EMPTY;
`endif
    endcase
    if (flush) state_nxt = EMPTY;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the data banks are reset too, because out_data must read zero straight after reset.
      state     <= EMPTY;
      main_data <= '0;
      main_ctrl <= '0;
      stall_cnt <= '0;
`ifdef PIPE_REG_SKID_EN
      skid_data  <= '0;
      skid_ctrl  <= '0;
      in_ready_q <= 1'b1;
`endif
    end else begin
      state <= state_nxt;
      if (out_valid && !out_ready && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;

      // A flushed cycle still completes the upstream handshake but stores nothing.
      if (!flush) begin
`ifdef PIPE_REG_SKID_EN
        case (state)
          EMPTY: if (acc) begin
            main_data <= in_data;
            main_ctrl <= in_ctrl;
          end
          ONE: begin
            if (acc && fire) begin
              main_data <= in_data;
              main_ctrl <= in_ctrl;
            end else if (acc) begin
              skid_data <= in_data;
              skid_ctrl <= in_ctrl;
            end
          end
          TWO: if (fire) begin
            main_data <= skid_data;
            main_ctrl <= skid_ctrl;
          end
          default: ;
        endcase
`else
        if (acc) begin
          main_data <= in_data;
          main_ctrl <= in_ctrl;
        end
`endif
      end

`ifdef PIPE_REG_SKID_EN
      in_ready_q <= (state_nxt != TWO);
`endif
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: vector table, directed corner sequences and a queue-based random reference.
// Skid-only sequences are compiled when PIPE_REG_SKID_EN is defined.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [7:0]  in_ctrl, out_ctrl;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(8)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .stall_cnt(stall_cnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: the stage is a FIFO of capacity 1 (or 2 with skid) in front of the outputs.
  typedef struct { logic [31:0] data; logic [7:0] ctrl; } entry_t;
  entry_t      mq[$];
  logic [31:0] m_data;
  logic [15:0] m_cnt;

  function automatic logic m_ready();
    if (rst) return 1'b0;
`ifdef PIPE_REG_SKID_EN
    return mq.size() < 2;
`else
    return mq.size() == 0 || out_ready;
`endif
  endfunction

  task automatic model_update();
    logic acc, fire;
    if (rst) begin
      mq.delete();
      m_data = '0;
      m_cnt  = '0;
    end else begin
      acc  = in_valid && m_ready();
      fire = mq.size() != 0 && out_ready;
      if (mq.size() != 0 && !out_ready && m_cnt != 16'hFFFF) m_cnt++;
      if (flush) mq.delete();
      else begin
        if (fire) void'(mq.pop_front());
        if (acc) mq.push_back('{in_data, in_ctrl});
        if (mq.size() != 0) m_data = mq[0].data;
      end
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".out_valid"}, out_valid, mq.size() != 0);
    check({tag, ".out_data"},  out_data,  m_data);
    check({tag, ".out_ctrl"},  out_ctrl,  mq.size() != 0 ? mq[0].ctrl : 8'h00);
    check({tag, ".in_ready"},  in_ready,  m_ready());
    check({tag, ".stall_cnt"}, stall_cnt, m_cnt);
  endtask

  // Values sampled mid-cycle by the last step, plus fired outputs when collecting.
  logic        s_ov, s_ir;
  logic [7:0]  s_oc;
  logic [15:0] s_sc;
  bit          collect = 1'b0;
  logic [31:0] got[$];

  task automatic drive(input logic r, f, v, input logic [31:0] d, input logic [7:0] c, input logic ordy);
    rst = r; flush = f; in_valid = v; in_data = d; in_ctrl = c; out_ready = ordy;
  endtask

  task automatic step(input logic r, f, v, input logic [31:0] d, input logic [7:0] c,
                      input logic ordy, input bit chk, input string tag);
    drive(r, f, v, d, c, ordy);
    @(negedge clk);
    if (chk) check_model(tag);
    s_ov = out_valid; s_ir = in_ready; s_oc = out_ctrl; s_sc = stall_cnt;
    if (collect && out_valid && out_ready) got.push_back(out_data);
    @(posedge clk);
    model_update();
    #1;
  endtask

  typedef struct {
    logic r, f, v; logic [31:0] d; logic [7:0] c; logic ordy;
    logic e_ov; logic [31:0] e_od; logic [7:0] e_oc; logic e_ir; logic chk_ir; logic [15:0] e_sc;
  } vec_t;

  function automatic vec_t mk(logic r, f, v, logic [31:0] d, logic [7:0] c, logic ordy,
                              logic e_ov, logic [31:0] e_od, logic [7:0] e_oc,
                              logic e_ir, logic chk_ir, logic [15:0] e_sc);
    vec_t t;
    t = '{r, f, v, d, c, ordy, e_ov, e_od, e_oc, e_ir, chk_ir, e_sc};
    return t;
  endfunction

  vec_t vecs[$];

  initial begin
    // Expected values are the outputs seen during the row's cycle, before its inputs are clocked.
    vecs.push_back(mk(1,0,1,32'h1234,8'h3C,1, 0,32'h0,8'h00,0,1,16'd0));
    vecs.push_back(mk(1,0,1,32'h1234,8'h3C,1, 0,32'h0,8'h00,0,1,16'd0));
    vecs.push_back(mk(0,0,1,32'h1234,8'h3C,1, 0,32'h0,8'h00,1,1,16'd0));
    vecs.push_back(mk(0,0,1,32'h5678,8'h81,1, 1,32'h1234,8'h3C,1,1,16'd0));
    vecs.push_back(mk(0,0,0,32'h0,8'h00,1,    1,32'h5678,8'h81,1,1,16'd0));
    vecs.push_back(mk(0,0,1,32'h0FF0,8'hFF,1, 0,32'h5678,8'h00,1,1,16'd0));
    vecs.push_back(mk(0,0,0,32'h0,8'h00,1,    1,32'h0FF0,8'hFF,1,1,16'd0));
    vecs.push_back(mk(0,0,0,32'h0,8'h00,1,    0,32'h0FF0,8'h00,1,1,16'd0));
    vecs.push_back(mk(0,1,1,32'hAAAA,8'h11,1, 0,32'h0FF0,8'h00,1,1,16'd0));
    vecs.push_back(mk(0,0,1,32'h2222,8'h22,1, 0,32'h0FF0,8'h00,1,1,16'd0));
    vecs.push_back(mk(0,0,0,32'h0,8'h00,0,    1,32'h2222,8'h22,0,0,16'd0));
    vecs.push_back(mk(0,0,0,32'h0,8'h00,0,    1,32'h2222,8'h22,0,0,16'd1));
    vecs.push_back(mk(0,0,0,32'h0,8'h00,1,    1,32'h2222,8'h22,1,1,16'd2));
    vecs.push_back(mk(0,0,0,32'h0,8'h00,1,    0,32'h2222,8'h00,1,1,16'd2));
    vecs.push_back(mk(1,0,0,32'h0,8'h00,1,    0,32'h2222,8'h00,0,1,16'd2));
    vecs.push_back(mk(0,0,0,32'h0,8'h00,1,    0,32'h0,8'h00,1,1,16'd0));

    drive(1, 0, 1, 32'h1234, 8'h3C, 1);
    @(posedge clk);
    model_update();
    #1;

    // Vector table.
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].r, vecs[i].f, vecs[i].v, vecs[i].d, vecs[i].c, vecs[i].ordy);
      @(negedge clk);
      check($sformatf("vec%0d.out_valid", i), out_valid, vecs[i].e_ov);
      check($sformatf("vec%0d.out_data", i),  out_data,  vecs[i].e_od);
      check($sformatf("vec%0d.out_ctrl", i),  out_ctrl,  vecs[i].e_oc);
      check($sformatf("vec%0d.stall_cnt", i), stall_cnt, vecs[i].e_sc);
      if (vecs[i].chk_ir) check($sformatf("vec%0d.in_ready", i), in_ready, vecs[i].e_ir);
      @(posedge clk);
      model_update();
      #1;
    end

    // Streaming: 0..99 back-to-back with out_ready held high.
    got.delete();
    collect = 1'b1;
    for (int i = 0; i < 100; i++) step(0, 0, 1, i, 8'hA5, 1, 1, "stream");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 8'h00, 1, 1, "stream_tail");
    collect = 1'b0;
    check("stream.count", got.size(), 100);
    for (int i = 0; i < got.size(); i++)
      if (got[i] !== i) check($sformatf("stream.order%0d", i), got[i], i);
    check("stream.stall_cnt", stall_cnt, 16'd0);

    // Flush drops an entry whose upstream handshake completes in the flush cycle.
    step(0, 0, 1, 32'hAA, 8'h0A, 0, 1, "flush1_load");
    step(0, 1, 1, 32'hCC, 8'h0C, 1, 1, "flush1_flush");
    check("flush1.in_ready_at_flush", s_ir, 1'b1);
    got.delete();
    collect = 1'b1;
    step(0, 0, 0, 0, 8'h00, 1, 1, "flush1_after");
    check("flush1.out_valid_after", s_ov, 1'b0);
    check("flush1.out_ctrl_after", s_oc, 8'h00);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 8'h00, 1, 1, "flush1_idle");
    collect = 1'b0;
    check("flush1.nothing_emitted", got.size(), 0);

`ifdef PIPE_REG_SKID_EN
    // Back-pressure into the skid entry, then drain.
    step(1, 0, 0, 0, 8'h00, 0, 1, "bp_rst");
    got.delete();
    collect = 1'b1;
    step(0, 0, 1, 32'h11, 8'h01, 0, 1, "bp_a");
    begin
      logic [15:0] base;
      base = s_sc;
      step(0, 0, 1, 32'h22, 8'h02, 0, 1, "bp_b");
      check("bp.in_ready_before_second", s_ir, 1'b1);
      step(0, 0, 1, 32'h33, 8'h03, 0, 1, "bp_c");
      check("bp.in_ready_full", s_ir, 1'b0);
      step(0, 0, 1, 32'h33, 8'h03, 0, 1, "bp_d");
      step(0, 0, 1, 32'h33, 8'h03, 1, 1, "bp_e");
      check("bp.stall_delta", s_sc - base, 16'd3);
    end
    step(0, 0, 1, 32'h33, 8'h03, 1, 1, "bp_f");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 8'h00, 1, 1, "bp_drain");
    collect = 1'b0;
    check("bp.count", got.size(), 3);
    if (got.size() == 3) begin
      check("bp.first", got[0], 32'h11);
      check("bp.second", got[1], 32'h22);
      check("bp.third", got[2], 32'h33);
    end

    // Flush while both entries are full.
    step(0, 0, 1, 32'hAA, 8'h0A, 0, 1, "flush2_a");
    step(0, 0, 1, 32'hBB, 8'h0B, 0, 1, "flush2_b");
    step(0, 1, 1, 32'hCC, 8'h0C, 0, 1, "flush2_flush");
    got.delete();
    collect = 1'b1;
    step(0, 0, 0, 0, 8'h00, 1, 1, "flush2_after");
    check("flush2.out_valid_after", s_ov, 1'b0);
    check("flush2.out_ctrl_after", s_oc, 8'h00);
    check("flush2.in_ready_after", s_ir, 1'b1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 8'h00, 1, 1, "flush2_idle");
    collect = 1'b0;
    check("flush2.nothing_emitted", got.size(), 0);
`endif

    // Randomized traffic against the reference model.
    for (int i = 0; i < 500; i++)
      step($urandom_range(0, 59) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
           $urandom, 8'($urandom), $urandom_range(0, 3) != 0, 1, "rnd");

    // Saturation of the stall counter.
    step(1, 0, 0, 0, 8'h00, 0, 1, "sat_rst");
    step(0, 0, 1, 32'h77, 8'h01, 0, 1, "sat_load");
    for (int i = 0; i < 70000; i++) step(0, 0, 0, 0, 8'h00, 0, 0, "");
    step(0, 0, 0, 0, 8'h00, 0, 1, "sat_hold");
    check("sat.stall_cnt_max", s_sc, 16'hFFFF);
    step(0, 0, 0, 0, 8'h00, 0, 1, "sat_nowrap");
    check("sat.stall_cnt_nowrap", s_sc, 16'hFFFF);
    step(1, 0, 0, 0, 8'h00, 0, 1, "sat_reset");
    step(0, 0, 0, 0, 8'h00, 1, 1, "sat_after_rst");
    check("sat.stall_cnt_cleared", s_sc, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
